// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for a dual-clock FIFO.
// Runs in the write clock domain. It synchronizes the Gray read pointer,
// keeps the binary and Gray write pointers, and produces the memory write
// address plus full, almost-full, level and sticky overflow status.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH     = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int ALMOST_FULL_TH = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   RPTR_GRAY,
  input  logic                  OVF_CLR,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   WPTR_GRAY,
  output logic                  W_FULL,
  output logic                  W_ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  W_OVF
);

  localparam int            PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq_gray;
  logic [PW-1:0] rq_bin;

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          ovf_q,   ovf_d;

  logic          wr_en;
  logic [PW-1:0] wbin_inc;

  // Plain flop chain on the incoming Gray read pointer; nothing between stages.
  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= RPTR_GRAY;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rq_bin = '0;
    for (int i = 0; i < PW; i++) rq_bin[i] = ^(rq_gray >> i);
  end

  // Full is a compare of registered values only, so it cannot glitch mid-cycle.
  assign W_FULL        = (wgray_q == {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]});
  assign wr_en         = W_INC & ~W_FULL;
  assign W_LEVEL       = wbin_q - rq_bin;
  assign W_ALMOST_FULL = (W_LEVEL >= AF_TH);

  // Next-state for pointers and sticky overflow; a new overflow beats a clear.
  always_comb begin
    wbin_inc = wbin_q + 1'b1;
    wbin_d   = wbin_q;
    wgray_d  = wgray_q;
    if (wr_en) begin
      wbin_d  = wbin_inc;
      wgray_d = wbin_inc ^ (wbin_inc >> 1);
    end
    ovf_d = (W_INC & W_FULL) | (ovf_q & ~OVF_CLR);
  end

  // Pointer and overflow registers.
  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign WPTR_GRAY = wgray_q;
  assign W_OVF     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: a fixed vector table for fill, overflow
// and a single read, hand sequences for wrap and async reset, then random
// traffic checked against an occupancy-counting reference model.
module tb_fifo_wr_ctrl;

  localparam int AW  = 3;
  localparam int SS  = 2;
  localparam int AFT = 6;
  localparam int DEPTH = 1 << AW;

  logic          W_CLK = 1'b0;
  logic          W_RST = 1'b1;
  logic          W_INC = 1'b0;
  logic [AW:0]   RPTR_GRAY = '0;
  logic          OVF_CLR = 1'b0;
  logic [AW-1:0] waddr;
  logic [AW:0]   WPTR_GRAY;
  logic          W_FULL;
  logic          W_ALMOST_FULL;
  logic [AW:0]   W_LEVEL;
  logic          W_OVF;

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .ALMOST_FULL_TH(AFT)) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .W_INC(W_INC), .RPTR_GRAY(RPTR_GRAY),
    .OVF_CLR(OVF_CLR), .waddr(waddr), .WPTR_GRAY(WPTR_GRAY), .W_FULL(W_FULL),
    .W_ALMOST_FULL(W_ALMOST_FULL), .W_LEVEL(W_LEVEL), .W_OVF(W_OVF)
  );

  always #5 W_CLK = ~W_CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: total accepted writes, read pointer as seen after the
  // synchronizer delay, and the sticky overflow flag.
  int wr_cnt;
  int rd_ptr;
  int rd_seen;
  int rq_hist[$];
  bit ovf_m;

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic int lvl_m();
    return ((wr_cnt % 16) - rd_seen + 16) % 16;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    wr_cnt  = 0;
    rd_ptr  = 0;
    rd_seen = 0;
    ovf_m   = 1'b0;
    rq_hist.delete();
    for (int i = 0; i < SS - 1; i++) rq_hist.push_back(0);
  endtask

  task automatic chk_model(input string tag);
    int l;
    l = lvl_m();
    chk({tag, " waddr"}, int'(waddr), wr_cnt % DEPTH);
    chk({tag, " wgray"}, int'(WPTR_GRAY), int'(gray(wr_cnt % 16)));
    chk({tag, " level"}, int'(W_LEVEL), l);
    chk({tag, " full"},  int'(W_FULL), int'(l == DEPTH));
    chk({tag, " afull"}, int'(W_ALMOST_FULL), int'(l >= AFT));
    chk({tag, " ovf"},   int'(W_OVF), int'(ovf_m));
  endtask

  // One write-clock cycle: drive at negedge, advance model at posedge, check 1 after.
  task automatic step(input bit inc, input bit clr, input int rbin, input bit do_chk, input string tag);
    bit full_now;
    @(negedge W_CLK);
    W_INC     = inc;
    OVF_CLR   = clr;
    RPTR_GRAY = gray(rbin % 16);
    @(posedge W_CLK);
    full_now = (lvl_m() == DEPTH);
    if (inc && full_now) ovf_m = 1'b1;
    else if (clr)        ovf_m = 1'b0;
    if (inc && !full_now) wr_cnt++;
    rq_hist.push_back(rbin % 16);
    rd_seen = rq_hist.pop_front();
    #1;
    if (do_chk) chk_model(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " waddr"}, int'(waddr), 0);
    chk({tag, " wgray"}, int'(WPTR_GRAY), 0);
    chk({tag, " full"},  int'(W_FULL), 0);
    chk({tag, " afull"}, int'(W_ALMOST_FULL), 0);
    chk({tag, " level"}, int'(W_LEVEL), 0);
    chk({tag, " ovf"},   int'(W_OVF), 0);
  endtask

  typedef struct packed {
    logic       inc;
    logic       clr;
    logic [3:0] rbin;
    logic [2:0] waddr;
    logic [3:0] wgray;
    logic       full;
    logic       af;
    logic [3:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // Fill from empty: level i+1 after vector i, full after the 8th write.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 1'b0, 4'd0, 3'((i + 1) % 8), gray(i + 1), 1'(i == 7), 1'(i + 1 >= AFT), 4'(i + 1), 1'b0};
    // Writes while full are dropped and set overflow.
    for (int i = 8; i < 11; i++)
      vecs[i] = '{1'b1, 1'b0, 4'd0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 4'd0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1}; // set beats clear
    vecs[12] = '{1'b0, 1'b1, 4'd0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0}; // clear alone
    // One read: full lingers for the synchronizer delay.
    vecs[13] = '{1'b0, 1'b0, 4'd1, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 4'd1, 3'd0, 4'b1100, 1'b0, 1'b1, 4'd7, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'd1, 3'd1, 4'b1101, 1'b1, 1'b1, 4'd8, 1'b0};

    // Reset state.
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge W_CLK);
    W_RST = 1'b0;

    // Vector table.
    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(vecs[i].inc, vecs[i].clr, int'(vecs[i].rbin), 1'b0, t);
      chk({t, " waddr"}, int'(waddr), int'(vecs[i].waddr));
      chk({t, " wgray"}, int'(WPTR_GRAY), int'(vecs[i].wgray));
      chk({t, " full"},  int'(W_FULL), int'(vecs[i].full));
      chk({t, " afull"}, int'(W_ALMOST_FULL), int'(vecs[i].af));
      chk({t, " level"}, int'(W_LEVEL), int'(vecs[i].lvl));
      chk({t, " ovf"},   int'(W_OVF), int'(vecs[i].ovf));
    end
    rd_ptr = 1;

    // Stream across the pointer wrap with the reader two entries behind.
    rd_ptr = wr_cnt - 2;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rd_ptr, 1'b1, "settle");
    chk("settle level2", int'(W_LEVEL), 2);
    for (int i = 0; i < 20; i++) begin
      rd_ptr = wr_cnt - 2;
      step(1'b1, 1'b0, rd_ptr, 1'b1, $sformatf("wrap%0d", i));
    end
    chk("wrap count", wr_cnt, 29);
    chk("wrap ovf", int'(W_OVF), 0);

    // Random traffic; the reader only advances over written entries, one step at a time.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && rd_ptr < wr_cnt) rd_ptr++;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), rd_ptr, 1'b1,
           $sformatf("rnd%0d", i));
    end

    // Fill up, then reset asynchronously between edges.
    for (int i = 0; i < 20 && lvl_m() != DEPTH; i++) step(1'b1, 1'b0, rd_ptr, 1'b1, "fill");
    chk("prerst full", int'(W_FULL), 1);
    @(negedge W_CLK);
    #2 W_RST = 1'b1;
    #1;
    chk_all_zero("asyncrst");
    model_reset();
    @(negedge W_CLK);
    W_INC = 1'b0;
    OVF_CLR = 1'b0;
    RPTR_GRAY = '0;
    @(negedge W_CLK);
    W_RST = 1'b0;
    chk("postrst waddr", int'(waddr), 0);
    step(1'b1, 1'b0, 0, 1'b1, "postrst");
    chk("postrst waddr1", int'(waddr), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side controller for the 8-entry asynchronous FIFO. Lives in the write clock domain and sits directly upstream of the FIFO memory, supplying its write address and full flag. Synchronizes the Gray-coded read pointer from the read domain. Maintains the binary and Gray write pointers, and produces full, almost-full, fill-level and sticky overflow status for the producer.

## Interface
Parameters:
- ADDR_WIDTH, 3: memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2: flip-flop stages on the read-pointer synchronizer; legal values ≥ 2.
- ALMOST_FULL_TH, 6: level at or above which W_ALMOST_FULL asserts; range 1..2^ADDR_WIDTH.

Ports:
- W_CLK  in  1  write-domain clock, rising edge.
- W_RST  in  1  asynchronous, active-high reset.
- W_INC  in  1  producer write request, sampled each W_CLK.
- RPTR_GRAY  in  ADDR_WIDTH+1  Gray read pointer from the read domain; asynchronous to W_CLK.
- OVF_CLR  in  1  clears W_OVF.
- waddr  out  ADDR_WIDTH  write address to memory; equals the low bits of the binary write pointer.
- WPTR_GRAY  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- W_FULL  out  1  FIFO full; a write is accepted only when this is low.
- W_ALMOST_FULL  out  1  level ≥ ALMOST_FULL_TH.
- W_LEVEL  out  ADDR_WIDTH+1  occupancy as seen from the write domain, 0..2^ADDR_WIDTH.
- W_OVF  out  1  sticky flag: a write was attempted while full.

## Operation
- Synchronizer: a chain of SYNC_STAGES registers on RPTR_GRAY. Its last stage is rq_gray. No logic is allowed between stages.
- rq_bin = Gray-to-binary(rq_gray), computed combinationally.
- Accept: wr_en = W_INC & ~W_FULL.
- On wr_en, wbin <= wbin + 1, modulo 2^(ADDR_WIDTH+1).
- WPTR_GRAY <= (wbin+1) ^ ((wbin+1) >> 1), updated in the same cycle as wbin.
- W_FULL = (WPTR_GRAY == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}).
  - It is a combinational compare of registered values, so it is glitch-free relative to the clock edge.
- W_LEVEL = wbin − rq_bin, modulo 2^(ADDR_WIDTH+1). It never exceeds 2^ADDR_WIDTH.
- W_ALMOST_FULL = (W_LEVEL ≥ ALMOST_FULL_TH). It is combinational from W_LEVEL.
- W_OVF:
  - Set on W_INC & W_FULL.
  - Cleared on OVF_CLR.
  - If both happen in the same cycle, set wins.
- Writes attempted while full are dropped. Pointers and waddr do not move.
- The memory writes at waddr on the same edge that advances wbin. waddr is the address of the current write.

## Timing
- Reset (async assert, release at a W_CLK edge):
  - wbin = 0, WPTR_GRAY = 0, all synchronizer stages = 0.
  - waddr = 0, W_FULL = 0, W_LEVEL = 0, W_ALMOST_FULL = 0, W_OVF = 0.
- Reset mid-operation clears everything immediately, regardless of clock. Pending synchronizer contents are discarded.
- Write latency: W_INC high at edge N advances waddr, W_LEVEL and WPTR_GRAY after edge N.
  - W_FULL asserts in the cycle after the 8th accepted write, so back-to-back writes are safe.
- Read-pointer latency: a RPTR_GRAY change is reflected in rq_gray, W_FULL, W_LEVEL and W_ALMOST_FULL after exactly SYNC_STAGES W_CLK edges.
  - Full deassertion is therefore pessimistic by that amount.
- Wrap-around: the pointer wraps 15→0 (binary). The Gray code wraps 1000→0000. Full/level arithmetic stays correct across the wrap.
- The state register holds between accepted writes. There is no other state machine.

## Test plan
- Reset, RPTR_GRAY=0, then W_INC high for 8 cycles:
  - waddr counts 0..7 and WPTR_GRAY reaches 1100.
  - W_LEVEL reaches 8 and W_FULL = 1 after the 8th edge.
  - W_ALMOST_FULL rises when W_LEVEL reaches 6.
- While full, W_INC for 3 more cycles:
  - waddr stays 0 and W_LEVEL stays 8.
  - W_OVF = 1 and stays set until an OVF_CLR pulse.
  - OVF_CLR and a full-write in the same cycle leave W_OVF = 1.
- From full, set RPTR_GRAY = 0001 (one read):
  - W_FULL stays 1 for 2 edges, then drops; W_LEVEL = 7.
  - The next W_INC is accepted.
- Stream 20 writes while RPTR_GRAY tracks the Gray of (wbin−2), held stable across each edge:
  - No full and no overflow.
  - waddr wraps 7→0, and WPTR_GRAY passes 1000→0000 cleanly.
  - W_LEVEL stays 2 (plus sync lag).
- Assert W_RST mid-stream with W_FULL=1:
  - All outputs return to 0 asynchronously, before the next edge.
  - The first write after release goes to waddr 0.
